// File: rtl/iq_split.sv
// iq_split: pairs serial bits into I/Q symbols held 2*SAMPLE cycles; IQ_SPLIT_UNDERRUN_CNT_EN adds underrun_cnt
module iq_split #(
    parameter int SAMPLE = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_i,
    input  logic        ser_valid,
    output logic        ser_ready,
    output logic        i_o,
    output logic        q_o,
    output logic        sym_start,
    output logic        sym_active
`ifdef IQ_SPLIT_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);
    localparam logic [8:0] last_cnt = 9'(2 * SAMPLE - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t     st;
    logic       half, pend, push, wp, rp, xfer, pop;
    logic [1:0] push_d, cnt, cnt_nxt;
    logic [1:0] mem [2];
    logic [8:0] sc;
    assign xfer    = ser_valid && ser_ready;
    assign pop     = cnt != 2'd0 && (st == IDLE || sc == last_cnt);
    assign cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            half       <= 1'b0;
            pend       <= 1'b0;
            push       <= 1'b0;
            push_d     <= 2'b00;
            wp         <= 1'b0;
            rp         <= 1'b0;
            cnt        <= 2'd0;
            sc         <= 9'd0;
            ser_ready  <= 1'b0;
            i_o        <= 1'b0;
            q_o        <= 1'b0;
            sym_start  <= 1'b0;
            sym_active <= 1'b0;
`ifdef IQ_SPLIT_UNDERRUN_CNT_EN
            underrun_cnt <= 16'd0;
`endif
        end else begin
            // the completed pair enters the FIFO one cycle after its second bit
            push <= xfer && pend;
            if (xfer && pend) push_d <= {half, ser_i};
            if (xfer) begin
                half <= ser_i;
                pend <= !pend;
            end
            if (push) begin
                mem[wp] <= push_d;
                wp      <= !wp;
            end
            if (pop) rp <= !rp;
            cnt       <= cnt_nxt;
            ser_ready <= cnt_nxt < 2'd2;
            sym_start <= pop;
            if (pop) begin
                {i_o, q_o} <= mem[rp];
                sc         <= 9'd0;
                st         <= RUN;
                sym_active <= 1'b1;
            end else if (st == RUN) begin
                if (sc == last_cnt) begin
                    st         <= IDLE;
                    {i_o, q_o} <= 2'b00;
                    sym_active <= 1'b0;
                    sc         <= 9'd0;
`ifdef IQ_SPLIT_UNDERRUN_CNT_EN
                    if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
`endif
                end else begin
                    sc <= sc + 9'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iq_split.sv
// tb_iq_split: scoreboard bench for iq_split at SAMPLE=4 (directed) and SAMPLE=2 (random stream)
module tb_iq_split;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic [1:0] rst, ser, val, rdy, io, qo, ss, sa;
`ifdef IQ_SPLIT_UNDERRUN_CNT_EN
    logic [15:0] uc0, uc1;
`endif
    iq_split #(.SAMPLE(4)) u4 (
        .clk(clk), .rst(rst[0]), .ser_i(ser[0]), .ser_valid(val[0]), .ser_ready(rdy[0]),
        .i_o(io[0]), .q_o(qo[0]), .sym_start(ss[0]), .sym_active(sa[0])
`ifdef IQ_SPLIT_UNDERRUN_CNT_EN
        , .underrun_cnt(uc0)
`endif
    );
    iq_split #(.SAMPLE(2)) u2 (
        .clk(clk), .rst(rst[1]), .ser_i(ser[1]), .ser_valid(val[1]), .ser_ready(rdy[1]),
        .i_o(io[1]), .q_o(qo[1]), .sym_start(ss[1]), .sym_active(sa[1])
`ifdef IQ_SPLIT_UNDERRUN_CNT_EN
        , .underrun_cnt(uc1)
`endif
    );
    int vectors = 0, errs = 0, cyc = 0, idle_cyc = 0, nsym1 = 0, gap_chk = 0;
    int st_cyc [2];
    bit saw_nrdy = 0;
    logic hb [2];
    logic pd [2];
    logic [1:0] sb0 [$];
    logic [1:0] sb1 [$];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    // each sym_start consumes the oldest expected pair
    always @(negedge clk) begin
        if (!sa[0]) idle_cyc++;
        if (!rdy[0] && !rst[0]) saw_nrdy = 1;
        if (ss[0]) begin
            if (sb0.size() == 0) check("u4 spurious sym", 1, 0);
            else check("u4 iq", {30'd0, io[0], qo[0]}, {30'd0, sb0.pop_front()});
            if (gap_chk != 0 && st_cyc[0] >= 0) begin
                check("u4 sym gap", cyc - st_cyc[0], 8);
                check("u4 inactive cycles", idle_cyc, 0);
            end
            st_cyc[0] = cyc;
            idle_cyc = 0;
        end
        if (ss[1]) begin
            nsym1++;
            if (sb1.size() == 0) check("u2 spurious sym", 1, 0);
            else check("u2 iq", {30'd0, io[1], qo[1]}, {30'd0, sb1.pop_front()});
        end
    end
    task automatic send(input int k, input logic b);
        int n = 0;
        @(negedge clk);
        ser[k] = b;
        val[k] = 1'b1;
        while (!rdy[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready timeout", 0, 1);
        @(posedge clk);
        if (pd[k]) begin
            if (k == 0) sb0.push_back({hb[k], b});
            else sb1.push_back({hb[k], b});
        end
        hb[k] = b;
        pd[k] = !pd[k];
    endtask
    task automatic idle(input int k, input int n);
        @(negedge clk);
        val[k] = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        int n;
        rst = 2'b11; val = 2'b00; ser = 2'b00;
        pd = '{1'b0, 1'b0}; hb = '{1'b0, 1'b0}; st_cyc = '{-1, -1};
        repeat (3) @(negedge clk);
        check("rst ready", rdy[0], 0);
        check("rst i", io[0], 0);
        check("rst q", qo[0], 0);
        check("rst start", ss[0], 0);
        check("rst active", sa[0], 0);
`ifdef IQ_SPLIT_UNDERRUN_CNT_EN
        check("rst underrun", uc0, 0);
`endif
        rst = 2'b00;
        @(negedge clk);
        check("ready after rst", rdy[0], 1);
        send(0, 1'b1);
        send(0, 1'b0);
        @(negedge clk);
        val[0] = 1'b0;
        check("lat1 start", ss[0], 0);
        @(negedge clk);
        check("lat2 start", ss[0], 0);
        check("lat2 i", io[0], 0);
        @(negedge clk);
        check("lat start", ss[0], 1);
        check("lat i", io[0], 1);
        check("lat q", qo[0], 0);
        check("lat active", sa[0], 1);
        repeat (7) begin
            @(negedge clk);
            check("hold i", io[0], 1);
            check("hold q", qo[0], 0);
            check("hold start", ss[0], 0);
            check("hold active", sa[0], 1);
        end
        @(negedge clk);
        check("underrun i", io[0], 0);
        check("underrun q", qo[0], 0);
        check("underrun active", sa[0], 0);
`ifdef IQ_SPLIT_UNDERRUN_CNT_EN
        check("underrun cnt 1", uc0, 1);
`endif
        st_cyc[0] = -1; gap_chk = 1; saw_nrdy = 0;
        for (int i = 0; i < 8; i++) send(0, 1'($urandom));
        idle(0, 60);
        gap_chk = 0;
        check("stream drained", sb0.size(), 0);
        check("stream ready dropped", {31'd0, saw_nrdy}, 1);
        check("stream idle", sa[0], 0);
        send(0, 1'b1); send(0, 1'b1); send(0, 1'b0);
        idle(0, 30);
        check("odd drained", sb0.size(), 0);
        check("odd idle", sa[0], 0);
        send(0, 1'b1);
        idle(0, 20);
        check("late pair drained", sb0.size(), 0);
`ifdef IQ_SPLIT_UNDERRUN_CNT_EN
        check("underrun cnt 4", uc0, 4);
`endif
        st_cyc[0] = -1;
        for (int i = 0; i < 6; i++) send(0, 1'($urandom));
        @(negedge clk);
        val[0] = 1'b0;
        n = 0;
        while ((st_cyc[0] < 0 || cyc < st_cyc[0] + 3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("sym cycle 3 reached", {31'd0, n < 100}, 1);
        check("fifo full", rdy[0], 0);
        rst[0] = 1'b1;
        @(negedge clk);
        check("midrst i", io[0], 0);
        check("midrst q", qo[0], 0);
        check("midrst start", ss[0], 0);
        check("midrst active", sa[0], 0);
        check("midrst ready", rdy[0], 0);
        sb0.delete();
        pd[0] = 1'b0;
        rst[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("post rst silent", sa[0], 0);
        send(0, 1'b0); send(0, 1'b1);
        idle(0, 20);
        check("post rst pair", sb0.size(), 0);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) idle(1, $urandom_range(1, 3));
            send(1, 1'($urandom));
        end
        idle(1, 30);
        check("random drained", sb1.size(), 0);
        check("random symbols", nsym1, 500);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
